instr_fetch: RTL and testbench

Instruction Fetch (IF) stage. It keeps the fetch PC, issues word requests on the instruction bus and buffers the returned instructions. It feeds the ID stage through the id_pipe valid/ready handshake. On a pipeline flush it redirects to a new PC and discards any stale in-flight data.

---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage holding the fetch PC, issuing single-outstanding word fetches and
// queueing {pc, instruction} pairs for ID. Build macro IF_BYPASS_EN enables same-cycle forwarding.
`ifndef XLEN
`define XLEN 32
`endif

module instr_fetch #(
    parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned      BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             id_pipe_ready,
    input  logic             id_pipe_flush,
    input  logic [`XLEN-1:0] redirect_pc,
    output logic             id_pipe_valid,
    output logic [`XLEN-1:0] id_pipe_pc,
    output logic [`XLEN-1:0] id_pipe_instruction,
    output logic             ibus_req,
    output logic [`XLEN-1:0] ibus_addr,
    input  logic             ibus_ready,
    input  logic             ibus_rvalid,
    input  logic [`XLEN-1:0] ibus_rdata
);
    localparam int unsigned      AW      = $clog2(BUF_DEPTH);
    localparam int unsigned      CW      = AW + 2;
    localparam logic [`XLEN-1:0] PC_STEP = `XLEN'(4);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0]    DEPTH_C = CW'(BUF_DEPTH);

    logic [`XLEN-1:0] pc_q, pc_d;
    logic [`XLEN-1:0] req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic             run_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [`XLEN-1:0] fifo_pc_q  [BUF_DEPTH];
    logic [`XLEN-1:0] fifo_ins_q [BUF_DEPTH];

    logic [AW:0]      count;
    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic             empty;
    logic             resp;
    logic             keep_resp;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             out_after;
    logic             accept;
    logic [CW-1:0]    occ_after;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign head_idx = rd_ptr_q[AW-1:0];
    assign tail_idx = wr_ptr_q[AW-1:0];

    // A response only counts when a request is actually in flight.
    assign resp      = ibus_rvalid & outstanding_q;
    assign keep_resp = resp & ~discard_q & ~id_pipe_flush;

`ifdef IF_BYPASS_EN
    assign bypass = empty & keep_resp;
`else
    assign bypass = 1'b0;
`endif

    assign push      = keep_resp & ~(bypass & id_pipe_ready);
    assign pop       = ~empty & id_pipe_ready & ~id_pipe_flush;
    assign out_after = outstanding_q & ~resp;

    // Occupancy after this cycle's push/pop must leave room for the new request's data.
    assign occ_after = CW'(count) + CW'(push) + CW'(out_after) - CW'(pop);

    assign ibus_req  = run_q & ~id_pipe_flush & (~outstanding_q | ibus_rvalid)
                     & (occ_after < DEPTH_C);
    assign ibus_addr = pc_q;
    assign accept    = ibus_req & ibus_ready;

    assign id_pipe_valid       = ~empty | bypass;
    assign id_pipe_pc          = bypass ? req_pc_q   : fifo_pc_q[head_idx];
    assign id_pipe_instruction = bypass ? ibus_rdata : fifo_ins_q[head_idx];

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (accept) begin
            pc_d          = pc_q + PC_STEP;
            req_pc_d      = pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp) begin
            discard_d = 1'b0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Flush overrides everything; a still-pending request must have its data thrown away.
        if (id_pipe_flush) begin
            pc_d      = redirect_pc;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            discard_d = out_after;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            run_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_q         <= 1'b1;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc_q[i]  <= '0;
                fifo_ins_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[tail_idx]  <= req_pc_q;
            fifo_ins_q[tail_idx] <= ibus_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a latency-programmable instruction bus model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        id_pipe_ready = 1'b1;
    logic        id_pipe_flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ibus_ready = 1'b1;
    logic        id_pipe_valid;
    logic [31:0] id_pipe_pc;
    logic [31:0] id_pipe_instruction;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;

    logic        mdl_rvalid = 1'b0;
    logic [31:0] mdl_rdata = '0;
    logic        man_en = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    int unsigned resp_lat = 1;
    logic        keep_late = 1'b0;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        pend = 1'b0;
    int unsigned lat_cnt = 0;
    logic [31:0] pend_addr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    assign ibus_rvalid = man_en ? man_rvalid : mdl_rvalid;
    assign ibus_rdata  = man_en ? man_rdata  : mdl_rdata;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_pipe_ready(id_pipe_ready), .id_pipe_flush(id_pipe_flush), .redirect_pc(redirect_pc),
        .id_pipe_valid(id_pipe_valid), .id_pipe_pc(id_pipe_pc),
        .id_pipe_instruction(id_pipe_instruction),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
    endfunction

    // Bus model: accept seen mid-cycle, data returned resp_lat cycles after the accepting edge.
    always @(negedge clk) begin
        acc_seen = ibus_req & ibus_ready;
        acc_addr = ibus_addr;
    end

    always @(posedge clk) begin
        #1;
        mdl_rvalid = 1'b0;
        if (!rst_b && !keep_late) begin
            pend = 1'b0;
        end else begin
            if (acc_seen) begin
                pend      = 1'b1;
                lat_cnt   = resp_lat;
                pend_addr = acc_addr;
            end
            if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    pend       = 1'b0;
                    mdl_rvalid = 1'b1;
                    mdl_rdata  = mem(pend_addr);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_b = 1'b0;
        id_pipe_flush = 1'b0;
        id_pipe_ready = 1'b1;
        ibus_ready = 1'b1;
        resp_lat = 1;
        keep_late = 1'b0;
        man_en = 1'b0;
        step;
        step;
        rst_b = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (id_pipe_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait_valid: got valid=%b want 1 within 30 cycles", name, id_pipe_valid);
        end
    endtask

    task automatic wait_req(input logic [31:0] addr, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (ibus_req === 1'b1 && ibus_ready === 1'b1 && ibus_addr === addr) begin
                ok = 1'b1;
                break;
            end
            step;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait_req: got addr=%h want request at %h within 60 cycles", name, ibus_addr, addr);
        end
        step;
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        step;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", id_pipe_valid); end
        n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", ibus_req); end
        n_cmp++; if (ibus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", ibus_addr); end
        n_cmp++; if (id_pipe_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", id_pipe_pc); end
        n_cmp++; if (id_pipe_instruction !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", id_pipe_instruction); end
    endtask

    task automatic test_stream;
        do_reset;
        wait_valid("stream");
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (id_pipe_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, id_pipe_valid); end
            n_cmp++; if (id_pipe_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, id_pipe_pc, 32'(4 * i)); end
            n_cmp++; if (id_pipe_instruction !== mem(32'(4 * i))) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, id_pipe_instruction, mem(32'(4 * i))); end
            step;
        end
    endtask

    task automatic test_id_stall;
        do_reset;
        id_pipe_ready = 1'b0;
        for (int i = 0; i < 6; i++) step;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, ibus_req); end
            n_cmp++; if (id_pipe_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, id_pipe_valid); end
            n_cmp++; if (id_pipe_pc !== 32'h0) begin n_bad++; $display("FAIL stall_pc[%0d]: got %h want 0", i, id_pipe_pc); end
            step;
        end
        id_pipe_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (id_pipe_valid !== 1'b1) begin n_bad++; $display("FAIL release_valid[%0d]: got %b want 1", i, id_pipe_valid); end
            n_cmp++; if (id_pipe_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL release_pc[%0d]: got %h want %h", i, id_pipe_pc, 32'(4 * i)); end
            n_cmp++; if (id_pipe_instruction !== mem(32'(4 * i))) begin n_bad++; $display("FAIL release_instr[%0d]: got %h want %h", i, id_pipe_instruction, mem(32'(4 * i))); end
            step;
        end
    endtask

    task automatic test_flush_outstanding;
        do_reset;
        resp_lat = 3;
        wait_req(32'h10, "flush_out");
        id_pipe_flush = 1'b1;
        redirect_pc = 32'h200;
        #1;
        n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL fo_req_in_flush: got %b want 0", ibus_req); end
        step;
        id_pipe_flush = 1'b0;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL fo_valid_after_flush: got %b want 0", id_pipe_valid); end
        #1;
        n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL fo_req_waiting: got %b want 0", ibus_req); end
        step;
        #1;
        n_cmp++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin n_bad++; $display("FAIL fo_redirect_req: got req=%b addr=%h want 1/00000200", ibus_req, ibus_addr); end
        step;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL fo_stale_dropped: got valid=%b pc=%h want valid 0", id_pipe_valid, id_pipe_pc); end
        wait_valid("flush_out");
        n_cmp++; if (id_pipe_pc !== 32'h200) begin n_bad++; $display("FAIL fo_pc: got %h want 00000200", id_pipe_pc); end
        n_cmp++; if (id_pipe_instruction !== mem(32'h200)) begin n_bad++; $display("FAIL fo_instr: got %h want %h", id_pipe_instruction, mem(32'h200)); end
    endtask

    task automatic test_flush_with_resp;
        do_reset;
        resp_lat = 2;
        wait_req(32'h10, "flush_resp");
        step;
        id_pipe_flush = 1'b1;
        redirect_pc = 32'h200;
        #1;
        n_cmp++; if (ibus_rvalid !== 1'b1 || ibus_req !== 1'b0) begin n_bad++; $display("FAIL fr_flush_cycle: got rvalid=%b req=%b want 1/0", ibus_rvalid, ibus_req); end
        step;
        id_pipe_flush = 1'b0;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL fr_valid_after_flush: got %b want 0", id_pipe_valid); end
        #1;
        n_cmp++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin n_bad++; $display("FAIL fr_redirect_req: got req=%b addr=%h want 1/00000200", ibus_req, ibus_addr); end
        wait_valid("flush_resp");
        n_cmp++; if (id_pipe_pc !== 32'h200) begin n_bad++; $display("FAIL fr_pc: got %h want 00000200", id_pipe_pc); end
        n_cmp++; if (id_pipe_instruction !== mem(32'h200)) begin n_bad++; $display("FAIL fr_instr: got %h want %h", id_pipe_instruction, mem(32'h200)); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        resp_lat = 4;
        wait_req(32'h10, "b2b");
        id_pipe_flush = 1'b1;
        redirect_pc = 32'h300;
        step;
        redirect_pc = 32'h400;
        step;
        id_pipe_flush = 1'b0;
        #1;
        n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL b2b_req_waiting: got %b want 0", ibus_req); end
        step;
        #1;
        n_cmp++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h400) begin n_bad++; $display("FAIL b2b_redirect_req: got req=%b addr=%h want 1/00000400", ibus_req, ibus_addr); end
        wait_valid("b2b");
        n_cmp++; if (id_pipe_pc !== 32'h400) begin n_bad++; $display("FAIL b2b_pc: got %h want 00000400", id_pipe_pc); end
        n_cmp++; if (id_pipe_instruction !== mem(32'h400)) begin n_bad++; $display("FAIL b2b_instr: got %h want %h", id_pipe_instruction, mem(32'h400)); end
    endtask

    task automatic test_bus_stall;
        do_reset;
        ibus_ready = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin n_bad++; $display("FAIL bs_hold[%0d]: got req=%b addr=%h want 1/00000000", i, ibus_req, ibus_addr); end
            n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL bs_valid[%0d]: got %b want 0", i, id_pipe_valid); end
            step;
        end
        ibus_ready = 1'b1;
        step;
        #1;
        n_cmp++; if (ibus_addr !== 32'h4) begin n_bad++; $display("FAIL bs_advance: got addr=%h want 00000004", ibus_addr); end
        step;
        n_cmp++; if (id_pipe_valid !== 1'b1 || id_pipe_pc !== 32'h0) begin n_bad++; $display("FAIL bs_first: got valid=%b pc=%h want 1/00000000", id_pipe_valid, id_pipe_pc); end
    endtask

    task automatic test_reset_midstream;
        do_reset;
        id_pipe_ready = 1'b0;
        for (int i = 0; i < 6; i++) step;
        resp_lat = 2;
        id_pipe_ready = 1'b1;
        step;
        id_pipe_ready = 1'b0;
        keep_late = 1'b1;
        #1;
        rst_b = 1'b0;
        #1;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid_low: got %b want 0", id_pipe_valid); end
        n_cmp++; if (ibus_req !== 1'b0) begin n_bad++; $display("FAIL mr_req_low: got %b want 0", ibus_req); end
        step;
        rst_b = 1'b1;
        resp_lat = 1;
        id_pipe_ready = 1'b1;
        n_cmp++; if (ibus_rvalid !== 1'b1) begin n_bad++; $display("FAIL mr_late_resp_present: got %b want 1", ibus_rvalid); end
        step;
        keep_late = 1'b0;
        n_cmp++; if (id_pipe_valid !== 1'b0) begin n_bad++; $display("FAIL mr_late_ignored: got valid=%b pc=%h want 0", id_pipe_valid, id_pipe_pc); end
        #1;
        n_cmp++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin n_bad++; $display("FAIL mr_restart_req: got req=%b addr=%h want 1/00000000", ibus_req, ibus_addr); end
        wait_valid("reset_mid");
        n_cmp++; if (id_pipe_pc !== 32'h0) begin n_bad++; $display("FAIL mr_pc: got %h want 00000000", id_pipe_pc); end
        n_cmp++; if (id_pipe_instruction !== mem(32'h0)) begin n_bad++; $display("FAIL mr_instr: got %h want %h", id_pipe_instruction, mem(32'h0)); end
        step;
        n_cmp++; if (id_pipe_pc !== 32'h4) begin n_bad++; $display("FAIL mr_pc_next: got %h want 00000004", id_pipe_pc); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_id_stall;
        test_flush_outstanding;
        test_flush_with_resp;
        test_back_to_back;
        test_bus_stall;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end
endmodule
